shared_mem_arbiter: RTL and testbench
=====================================

# shared_mem_arbiter

Arbiter and sequencer for the single unified instruction/data memory of the multicycle MIPS core. It shares the memory between two requesters: the CPU port (fetch and load/store, address already muxed by the datapath) and a debug/loader port. Each access follows a fixed-latency issue/wait/complete sequence. Ties between the two ports are resolved round-robin.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 2: memory read latency in cycles, legal range 1..15.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  CPU access request; held until `cpu_done`.
- `cpu_we`  in  1  CPU write enable.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_done`  out  1  one-cycle completion pulse for the CPU.
- `cpu_rdata`  out  DATA_W  read data register, shared with `dbg_rdata`.
- `cpu_stall`  out  1  equals `cpu_req & ~cpu_done`; combinational.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/1/ADDR_W/DATA_W  debug port; same protocol as the CPU port.
- `dbg_done`  out  1  one-cycle completion pulse for the debug port.
- `dbg_rdata`  out  DATA_W  same register as `cpu_rdata`.
- `mem_en`  out  1  memory access strobe, one cycle per access.
- `mem_we`  out  1  memory write enable, valid while `mem_en`=1.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid MEM_LAT cycles after the `mem_en` cycle.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: drive memory for 1 cycle.
  - WAIT: count down MEM_LAT cycles.
  - DONE: pulse `done` for 1 cycle.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the port that is not `last_owner`.
  - On grant: latch owner, `we`, `addr`, `wdata` into registers; set `last_owner` = owner; go to ISSUE.
- ISSUE:
  - `mem_en`=1; `mem_we`/`mem_addr`/`mem_wdata` come from the latched registers.
  - Load counter with MEM_LAT; go to WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When the counter reaches 1: if the latched `we`=0, capture `mem_rdata` into the rdata register; go to DONE.
  - Writes use the same sequence and latency; the rdata register is unchanged on writes.
- DONE:
  - Pulse the owner's `done` for 1 cycle; the other port's `done` stays 0.
  - Go to IDLE.
- `mem_addr`/`mem_wdata`/`mem_we` hold their last driven values outside ISSUE; `mem_we` is forced 0 whenever `mem_en`=0.
- The latched payload is used for the whole access. Changes to the requester's inputs after grant have no effect.
- If the owner drops `req` mid-access, the access completes and `done` still pulses.
- Requesters must deassert or renew `req` in the cycle after `done`. IDLE re-arbitrates on that cycle, so a held `req` starts a new access.

## Timing
- Reset (async, `rst_n`=0):
  - State IDLE; counter 0.
  - `last_owner` = DBG, so the CPU wins the first tie.
  - `mem_en`, `mem_we`, `cpu_done`, `dbg_done`, `busy` = 0.
  - `mem_addr`, `mem_wdata`, rdata register = 0.
  - `cpu_stall` follows `cpu_req`.
- Reset mid-access: outputs go to reset values immediately, without waiting for a clock edge. No `done` is produced. A memory write already issued is not undone.
- Latency, with `req` first seen in IDLE at cycle 0:
  - ISSUE at cycle 1.
  - WAIT at cycles 2..1+MEM_LAT; data captured at the end of cycle 1+MEM_LAT.
  - `done` at cycle 2+MEM_LAT.
  - `rdata` is valid in the `done` cycle and holds until the next read capture.
- Back-to-back accesses: when `req` is held continuously, the period is 3+MEM_LAT cycles, with one IDLE cycle between accesses.
- Simultaneous requests: arbitration alternates strictly. Neither port waits more than one full access.

## Test plan
- Single CPU read, MEM_LAT=2, `cpu_addr`=0x40, memory returns 0xDEADBEEF → `mem_en` in cycle 1 with `mem_addr`=0x40, `mem_we`=0; `cpu_done` in cycle 4; `cpu_rdata`=0xDEADBEEF; `dbg_done` stays 0.
- Debug write of 0x12345678 to 0x100, followed by a CPU read of 0x100 → `mem_we`=1 only in the write's ISSUE cycle; the CPU read returns 0x12345678; the rdata register is unchanged by the write.
- `cpu_req` and `dbg_req` both asserted from reset and held for 4 accesses → grant order CPU, DBG, CPU, DBG; `done` pulses spaced 5 cycles apart (MEM_LAT=2).
- CPU changes `cpu_addr` from 0x40 to 0x80 during WAIT → memory access still uses 0x40; `cpu_done` timing unchanged.
- `rst_n` driven low during WAIT → `busy`, `mem_en`, `cpu_done` go to 0 immediately; after release, the next request completes at cycle 2+MEM_LAT and the CPU wins the tie.
- MEM_LAT=1 and MEM_LAT=15 builds → `done` at cycle 3 and cycle 17 respectively.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer that shares the unified MIPS
// memory between the CPU port and the debug/loader port.
module shared_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W   = 4;
  localparam logic        OWN_CPU = 1'b0;
  localparam logic        OWN_DBG = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               last_owner;
  logic               owner;
  logic               lat_we;
  logic [DATA_W-1:0]  rdata_q;

  logic               grant_c;
  logic               grant_dbg_c;
  logic               sel_we_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [DATA_W-1:0]  sel_wdata_c;

  // Arbitration: a lone request wins; on a tie the port that did not own last time wins.
  always_comb begin
    grant_c     = cpu_req | dbg_req;
    grant_dbg_c = dbg_req & (~cpu_req | (last_owner == OWN_CPU));
    sel_we_c    = grant_dbg_c ? dbg_we    : cpu_we;
    sel_addr_c  = grant_dbg_c ? dbg_addr  : cpu_addr;
    sel_wdata_c = grant_dbg_c ? dbg_wdata : cpu_wdata;
  end

  // mem_addr/mem_wdata double as the latched payload and hold between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_owner <= OWN_DBG;
      owner      <= OWN_CPU;
      lat_we     <= 1'b0;
      rdata_q    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_done   <= 1'b0;
      dbg_done   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_c) begin
            owner      <= grant_dbg_c;
            last_owner <= grant_dbg_c;
            lat_we     <= sel_we_c;
            mem_addr   <= sel_addr_c;
            mem_wdata  <= sel_wdata_c;
            mem_en     <= 1'b1;
            mem_we     <= sel_we_c;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CNT_W'(MEM_LAT);
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (!lat_we) rdata_q <= mem_rdata;
            cpu_done <= (owner == OWN_CPU);
            dbg_done <= (owner == OWN_DBG);
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;
  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: vector table plus scoreboards of
// expected memory issues and done pulses, with a behavioural latency-2 memory.
module tb_shared_mem_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic        cpu_done, cpu_stall, dbg_done, mem_en, mem_we, busy;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        lreq = 1'b0;

  logic        l1_cpu_done, l1_cpu_stall, l1_dbg_done, l1_mem_en, l1_mem_we, l1_busy;
  logic [31:0] l1_cpu_rdata, l1_dbg_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l15_cpu_done, l15_cpu_stall, l15_dbg_done, l15_mem_en, l15_mem_we, l15_busy;
  logic [31:0] l15_cpu_rdata, l15_dbg_rdata, l15_mem_addr, l15_mem_wdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } issue_t;
  typedef struct { logic port; logic [31:0] rdata; int cyc; } done_t;
  typedef struct { logic port; logic we; logic [31:0] addr; logic [31:0] wdata;
                   logic [31:0] exp; logic mut; } vec_t;

  issue_t iq[$];
  done_t  dq[$];
  vec_t   vecs[7];

  shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(lreq), .cpu_we(1'b0), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(l1_cpu_done), .cpu_rdata(l1_cpu_rdata), .cpu_stall(l1_cpu_stall),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
    .dbg_done(l1_dbg_done), .dbg_rdata(l1_dbg_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(32'h0), .busy(l1_busy)
  );

  shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) u_l15 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(lreq), .cpu_we(1'b0), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(l15_cpu_done), .cpu_rdata(l15_cpu_rdata), .cpu_stall(l15_cpu_stall),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
    .dbg_done(l15_dbg_done), .dbg_rdata(l15_dbg_rdata),
    .mem_en(l15_mem_en), .mem_we(l15_mem_we), .mem_addr(l15_mem_addr), .mem_wdata(l15_mem_wdata),
    .mem_rdata(32'h0), .busy(l15_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is driven only in the cycle LAT after mem_en.
  logic [31:0] mem [0:255];
  logic [31:0] pipe0 = '0, pipe1 = '0;
  logic [1:0]  vld = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    pipe0 <= mem[mem_addr[9:2]];
    pipe1 <= pipe0;
    vld   <= {vld[0], mem_en & ~mem_we};
  end
  assign mem_rdata = vld[1] ? pipe1 : 32'hBAD0_BAD0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void exp_issue(input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
    issue_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = d;
    iq.push_back(e);
  endfunction

  function automatic void exp_done(input logic p, input logic [31:0] r, input int c);
    done_t e;
    e.port = p; e.rdata = r; e.cyc = c;
    dq.push_back(e);
  endfunction

  function automatic vec_t mk(input logic p, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] x, input logic m);
    vec_t v;
    v.port = p; v.we = we; v.addr = a; v.wdata = d; v.exp = x; v.mut = m;
    return v;
  endfunction

  // Scoreboard monitor: every memory strobe and done pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we && !mem_en) chk("mem_we_without_en", 32'(mem_we), 32'h0);
      if (mem_en) begin
        if (iq.size() == 0) chk("unexpected_issue", 32'(mem_en), 32'h0);
        else begin
          issue_t e;
          e = iq.pop_front();
          chk("issue_cycle", 32'(cyc), 32'(e.cyc));
          chk("issue_we", 32'(mem_we), 32'(e.we));
          chk("issue_addr", mem_addr, e.addr);
          if (e.we) chk("issue_wdata", mem_wdata, e.wdata);
        end
      end
      if (cpu_done || dbg_done) begin
        chk("done_both", 32'(cpu_done & dbg_done), 32'h0);
        if (dq.size() == 0) chk("unexpected_done", 32'(cpu_done | dbg_done), 32'h0);
        else begin
          done_t e;
          e = dq.pop_front();
          chk("done_port", 32'(dbg_done), 32'(e.port));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("cpu_rdata", cpu_rdata, e.rdata);
          chk("dbg_rdata", dbg_rdata, e.rdata);
        end
      end
    end
  end

  task automatic drive_port(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    else   begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
  endtask

  task automatic do_access(input vec_t v);
    bit got;
    @(negedge clk);
    drive_port(v.port, v.we, v.addr, v.wdata);
    exp_issue(cyc + 1, v.we, v.addr, v.wdata);
    exp_done(v.port, v.exp, cyc + 2 + LAT);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (v.mut && i == 1) begin cpu_addr = 32'h80; cpu_wdata = 32'h5555_5555; end
      if (v.port ? dbg_done : cpu_done) got = 1'b1;
    end
    if (!got) chk("access_timeout", 32'h0, 32'h1);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, ndone, d1, d15;
    bit got;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEAD_BEEF;
    mem[8'h20] = 32'h1111_1111;

    vecs[0] = mk(1'b0, 1'b0, 32'h40,  32'h0,         32'hDEAD_BEEF, 1'b0);
    vecs[1] = mk(1'b1, 1'b1, 32'h100, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
    vecs[2] = mk(1'b0, 1'b0, 32'h100, 32'h0,         32'h1234_5678, 1'b0);
    vecs[3] = mk(1'b1, 1'b0, 32'h40,  32'h0,         32'hDEAD_BEEF, 1'b0);
    vecs[4] = mk(1'b0, 1'b1, 32'h44,  32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0);
    vecs[5] = mk(1'b1, 1'b0, 32'h44,  32'h0,         32'hCAFE_F00D, 1'b0);
    vecs[6] = mk(1'b0, 1'b0, 32'h40,  32'h0,         32'hDEAD_BEEF, 1'b1);

    // Reset state, with the combinational stall following cpu_req.
    #12;
    cpu_req = 1'b1;
    #1 chk("rst_stall_hi", 32'(cpu_stall), 32'h1);
    cpu_req = 1'b0;
    #1 chk("rst_stall_lo", 32'(cpu_stall), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_cpu_done", 32'(cpu_done), 32'h0);
    chk("rst_dbg_done", 32'(dbg_done), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_access(vecs[i]);

    // Both ports held from reset: strict alternation starting with the CPU.
    do_reset();
    @(negedge clk);
    n = cyc;
    drive_port(1'b0, 1'b0, 32'h40, 32'h0);
    drive_port(1'b1, 1'b0, 32'h100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      exp_issue(n + 1 + k * (3 + LAT), 1'b0, (k % 2 == 0) ? 32'h40 : 32'h100, 32'h0);
      exp_done(1'(k % 2), (k % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678, n + 4 + k * (3 + LAT));
    end
    ndone = 0;
    for (int i = 0; i < 40 && ndone < 4; i++) begin
      @(negedge clk);
      if (cpu_done || dbg_done) ndone++;
    end
    chk("tie_done_count", 32'(ndone), 32'h4);
    cpu_req = 1'b0;
    dbg_req = 1'b0;

    // Asynchronous reset during WAIT, then a fresh tie after release.
    @(negedge clk);
    drive_port(1'b0, 1'b0, 32'h40, 32'h0);
    exp_issue(cyc + 1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_mem_en", 32'(mem_en), 32'h0);
    chk("midrst_cpu_done", 32'(cpu_done), 32'h0);
    chk("midrst_rdata", cpu_rdata, 32'h0);
    chk("midrst_stall", 32'(cpu_stall), 32'h1);
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n = cyc;
    drive_port(1'b0, 1'b0, 32'h40, 32'h0);
    drive_port(1'b1, 1'b0, 32'h100, 32'h0);
    exp_issue(n + 1, 1'b0, 32'h40, 32'h0);
    exp_done(1'b0, 32'hDEAD_BEEF, n + 2 + LAT);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_done || dbg_done) got = 1'b1;
    end
    chk("postrst_done_seen", 32'(got), 32'h1);
    cpu_req = 1'b0;
    dbg_req = 1'b0;

    // Latency extremes on the MEM_LAT=1 and MEM_LAT=15 instances.
    do_reset();
    @(negedge clk);
    n = cyc;
    lreq = 1'b1;
    d1 = -1;
    d15 = -1;
    for (int i = 0; i < 30 && d15 < 0; i++) begin
      @(negedge clk);
      if (l1_cpu_done && d1 < 0) d1 = cyc - n;
      if (l15_cpu_done && d15 < 0) d15 = cyc - n;
    end
    lreq = 1'b0;
    chk("lat1_done_cycle", 32'(d1), 32'd3);
    chk("lat15_done_cycle", 32'(d15), 32'd17);

    repeat (3) @(negedge clk);
    chk("issue_queue_empty", 32'(iq.size()), 32'h0);
    chk("done_queue_empty", 32'(dq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
